// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared types and widths for the 8-input round-robin mux arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mux_arb_pkg;

  localparam int N_REQ = 8;
  localparam int SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } arb_state_t;

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] i);
    return {{(N_REQ-1){1'b0}}, 1'b1} << i;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/grant bundle between the eight requesters and the mux arbiter.
// Latency: n/a (wires only).
// Backpressure: requesters hold req until granted; done releases the grant.
interface mux8_rr_arbiter_if;
  import mux_arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic [N_REQ-1:0] grant;
  logic             busy;

  // Requester side drives requests and release.
  modport master (
    output req, done,
    input  sel, en, grant, busy
  );

  // Arbiter side drives the mux controls.
  modport slave (
    input  req, done,
    output sel, en, grant, busy
  );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Round-robin picker: first set request bit at or after ptr, wrapping mod 8.
// Latency: purely combinational.
// Backpressure: none; valid simply reflects any request present.
module rr_pick8
  import mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             valid,
  output logic [SEL_W-1:0] idx
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  // Rotate so that bit ptr lands at position 0; 3-bit index add wraps 7->0.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[SEL_W'(ptr + SEL_W'(i))];
    end
  end

  // Priority encode the rotated vector, lowest bit wins.
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  assign valid = |req;
  assign idx   = ptr + off;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter/sequencer for the 8:1 mux; optional hold timeout under MUX_ARB_TIMEOUT_EN.
// Latency: req sampled in IDLE gives en one cycle later; release costs 2 dead cycles before next grant.
// Backpressure: grantee keeps the mux until done, req drop, or (timeout build) MAX_HOLD cycles.
module mux8_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic               clk,
  input  logic               rst,
  mux8_rr_arbiter_if.slave   bus
);

  // Reject out-of-range hold limits at elaboration; the counter is 8 bits wide.
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mux8_rr_arbiter: MAX_HOLD must be in 1..255");
  end

  arb_state_t       state_q;
  arb_state_t       state_d;
  logic [SEL_W-1:0] ptr_q;
  logic [SEL_W-1:0] sel_q;
  logic             en_q;
  logic [N_REQ-1:0] grant_q;
  logic             busy_q;

  logic             pick_vld;
  logic [SEL_W-1:0] pick_idx;
  logic             start;
  logic             timeout;
  logic             release_now;

  rr_pick8 u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .valid (pick_vld),
    .idx   (pick_idx)
  );

  assign start       = (state_q == ST_IDLE) && pick_vld;
  // done and a req drop in the same cycle are simply one release.
  assign release_now = bus.done || !bus.req[sel_q] || timeout;

`ifdef MUX_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] hold_cnt;

  // Count GRANT cycles; cleared as a new grant starts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (start) begin
      hold_cnt <= '0;
    end else if (state_q == ST_GRANT) begin
      hold_cnt <= hold_cnt + 8'd1;
    end
  end

  assign timeout = (state_q == ST_GRANT) && (hold_cnt == HOLD_LAST);
`else
  assign timeout = 1'b0;
`endif

  // Next-state logic; the unused 2'b11 encoding falls back to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (pick_vld)    state_d = ST_GRANT;
      ST_GRANT: if (release_now) state_d = ST_GAP;
      ST_GAP:                    state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Pointer and select only move on a new grant; the winner drops to lowest priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      sel_q <= '0;
    end else if (start) begin
      ptr_q <= pick_idx + SEL_W'(1);
      sel_q <= pick_idx;
    end
  end

  // Registered mux controls, derived from the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q    <= 1'b0;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      en_q   <= (state_d == ST_GRANT);
      busy_q <= (state_d != ST_IDLE);
      if (state_d != ST_GRANT) grant_q <= '0;
      else if (start)          grant_q <= onehot(pick_idx);
    end
  end

  assign bus.sel   = sel_q;
  assign bus.en    = en_q;
  assign bus.grant = grant_q;
  assign bus.busy  = busy_q;

endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter with a grant-order scoreboard.
// Latency: checks 1-cycle grant latency and 2-cycle dead time.
// Backpressure: exercises done, request drop and (timeout build) hold expiry.
module tb_mux8_rr_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   exp_q[$];
  logic en_prev = 1'b0;

  mux8_rr_arbiter_if bus();

  mux8_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Scoreboard: every rising en must match the next queued grantee.
  always @(negedge clk) begin
    if (bus.en && !en_prev) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $error("FAIL sb_unexpected: observed grant sel=%0d expected no grant", bus.sel);
      end else begin
        check("sb_sel", 32'(bus.sel), 32'(exp_q.pop_front()));
      end
    end
    en_prev = bus.en;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] g;
    logic       hold_pat [7];

    bus.req  = 8'h00;
    bus.done = 1'b0;
    step(2);
    check("rst_en",    32'(bus.en),    0);
    check("rst_sel",   32'(bus.sel),   0);
    check("rst_grant", 32'(bus.grant), 0);
    check("rst_busy",  32'(bus.busy),  0);
    rst = 1'b0;
    step(1);

    // Fairness: all requesting, done one cycle after each grant.
    for (int k = 0; k < 8; k++) exp_q.push_back(k);
    exp_q.push_back(0);
    bus.req = 8'hFF;
    step(1);
    for (int k = 0; k < 9; k++) begin
      g = 8'd1 << (k % 8);
      check("fair_en", 32'(bus.en), 1);
      check("fair_grant", 32'(bus.grant), 32'(g));
      bus.done = 1'b1;
      if (k == 8) bus.req = 8'h00;
      step(1);
      bus.done = 1'b0;
      check("fair_gap_en", 32'(bus.en), 0);
      check("fair_gap_busy", 32'(bus.busy), 1);
      step(1);
      check("fair_idle_en", 32'(bus.en), 0);
      check("fair_idle_busy", 32'(bus.busy), 0);
      step(1);
    end
    check("fair_end_en", 32'(bus.en), 0);

    // Idle: done pulses with no requests do nothing; ptr stays at 1.
    for (int i = 0; i < 4; i++) begin
      bus.done = (i % 2 == 0);
      step(1);
      check("idle_busy", 32'(bus.busy), 0);
      check("idle_en", 32'(bus.en), 0);
    end
    bus.done = 1'b0;
    bus.req  = 8'h03;
    exp_q.push_back(1);
    step(1);
    check("idle_ptr_sel", 32'(bus.sel), 1);
    bus.done = 1'b1;
    bus.req  = 8'h00;
    step(1);
    bus.done = 1'b0;
    step(2);

    // Wrap: grant 6, then 0 beats 6 since search starts at 7.
    bus.req = 8'h40;
    exp_q.push_back(6);
    step(1);
    check("wrap_g6", 32'(bus.sel), 6);
    bus.done = 1'b1;
    bus.req  = 8'h41;
    exp_q.push_back(0);
    step(1);
    bus.done = 1'b0;
    step(2);
    check("wrap_en", 32'(bus.en), 1);
    check("wrap_sel", 32'(bus.sel), 0);
    bus.req = 8'h00;
    step(3);

    // Request drop, with req[5] toggling during the grant.
    bus.req = 8'h08;
    exp_q.push_back(3);
    step(1);
    check("drop_sel", 32'(bus.sel), 3);
    bus.req = 8'h28;
    step(1);
    check("drop_t1_en", 32'(bus.en), 1);
    check("drop_t1_sel", 32'(bus.sel), 3);
    bus.req = 8'h08;
    step(1);
    check("drop_t2_grant", 32'(bus.grant), 32'h08);
    bus.req = 8'h20;
    exp_q.push_back(5);
    step(1);
    check("drop_gap_en", 32'(bus.en), 0);
    check("drop_gap_sel", 32'(bus.sel), 3);
    check("drop_gap_grant", 32'(bus.grant), 0);
    check("drop_gap_busy", 32'(bus.busy), 1);
    step(2);
    check("drop_next_sel", 32'(bus.sel), 5);
    bus.done = 1'b1;
    bus.req  = 8'h00;
    step(1);
    bus.done = 1'b0;
    step(2);

    // Hold: single requester, done never asserted.
`ifdef MUX_ARB_TIMEOUT_EN
    hold_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_q.push_back(0);
    exp_q.push_back(0);
`else
    hold_pat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_q.push_back(0);
`endif
    bus.req = 8'h01;
    step(1);
    for (int i = 0; i < 7; i++) begin
      check($sformatf("hold_en_%0d", i), 32'(bus.en), 32'(hold_pat[i]));
      step(1);
    end
    bus.req = 8'h00;
    step(3);

    // Asynchronous reset mid-grant, then regrant right after release.
    bus.req = 8'h04;
    exp_q.push_back(2);
    step(1);
    check("pre_rst_sel", 32'(bus.sel), 2);
    #2 rst = 1'b1;
    #1;
    check("arst_en",    32'(bus.en),    0);
    check("arst_grant", 32'(bus.grant), 0);
    check("arst_sel",   32'(bus.sel),   0);
    check("arst_busy",  32'(bus.busy),  0);
    step(1);
    rst = 1'b0;
    exp_q.push_back(2);
    step(1);
    check("post_rst_en",  32'(bus.en),  1);
    check("post_rst_sel", 32'(bus.sel), 2);
    bus.req = 8'h00;
    step(3);

    check("sb_drain", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
